seq_gen_serial: RTL and testbench
=================================

Name: seq_gen_serial

Overview:
Serial bit-pattern transmitter. It loads a programmable pattern of up to MAX_LEN bits and shifts it out MSB-first on a single-bit line, one bit per clock. It repeats the pattern a programmable number of times, with a programmable idle gap between repeats. It drives the Mealy sequence detectors (e.g. the 11x1 detector) in system benches and BIST, and produces the framed serial input those detectors consume.

Parameters:
MAX_LEN, 8, maximum pattern length in bits
LEN_W, 4, width of length and bit-index fields; must satisfy 2^LEN_W > MAX_LEN
REP_W, 8, width of repeat count
GAP_W, 4, width of inter-frame gap count

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
i_start  input  1  request to begin a transmission; sampled only in IDLE
i_abort  input  1  synchronous abort, any state
i_pattern  input  MAX_LEN  pattern; the bit sent first is i_pattern[i_len-1]
i_len  input  LEN_W  number of bits per frame
i_repeat  input  REP_W  number of frames to send; 0 is treated as 1
i_gap  input  GAP_W  idle cycles between frames
o_seq  output  1  serial data bit; 0 when o_valid=0
o_valid  output  1  o_seq carries a pattern bit this cycle
o_sof  output  1  first bit of each frame (coincident with o_valid)
o_busy  output  1  transmission in progress
o_done  output  1  one-cycle pulse after the last bit of the last frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; o_seq, o_valid, o_sof, o_busy and o_done all 0; counters and shadow registers cleared. Takes effect immediately, including mid-frame.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, SHIFT, GAP, DONE. Encoding is 2-bit binary; the default case goes to IDLE.
- IDLE, i_start=1 and i_len!=0 in cycle n:
  - Capture pattern, len (clamped to MAX_LEN if larger), repeat (0 becomes 1) and gap into shadow registers.
  - Go to SHIFT.
  - Cycle n+1: o_valid=1, o_sof=1, o_busy=1, o_seq=pattern[len-1].
- IDLE, i_start=1 and i_len=0: request ignored; stay IDLE, no o_done.
- SHIFT:
  - Bit index counts down from len-1 to 0; one bit per cycle; o_valid=1.
  - o_sof=1 only on index len-1.
  - After index 0, with frames remaining: if gap>0, go to GAP; if gap=0, start the next frame in the immediately following cycle (back-to-back, o_sof=1).
  - After index 0 of the final frame: go to DONE.
- GAP: o_valid=0, o_seq=0, o_busy=1 for exactly gap cycles, then SHIFT at index len-1.
- DONE: o_done=1 and o_busy=0 for one cycle, then IDLE.
  - i_start in the DONE cycle is ignored.
  - i_start in the following IDLE cycle is accepted.
- i_start while o_busy=1: ignored. Shadow registers are not updated; input changes mid-transmission have no effect.
- i_abort=1 in any non-IDLE state: IDLE at the next edge; o_valid, o_sof, o_busy = 0; o_done is not pulsed.
- i_abort and i_start together in IDLE: abort wins; no start.
- Frame length L, R frames, gap G, start in cycle n:
  - o_done in cycle n + R*L + (R-1)*G + 1.
  - Total o_valid cycles = R*L.
- Repeat counter counts down from R. Width REP_W, so R=255 must work with no wrap.

Decomposition:
- Shared package seq_pkg:
  - State-encoding constants (IDLE/SHIFT/GAP/DONE).
  - MAX_LEN, LEN_W, REP_W and GAP_W defaults, also used by the detector benches.
- One sub-module, seq_gen_dncnt: loadable down-counter.
  - Ports: clk, rst_n, load, load value, enable, count output, zero flag.
  - Parameterised width.
  - Instantiated three times: bit index, repeat count, gap count.

Test Plan:
- Single frame: pattern=4'b1101, len=4, repeat=1, gap=0, start in cycle 10.
  - o_seq=1,1,0,1 with o_valid=1 in cycles 11-14.
  - o_sof only in cycle 11.
  - o_done in cycle 15; o_busy high in cycles 11-14.
- Repeats with gap: pattern=4'b1111, len=4, repeat=3, gap=2.
  - 12 valid cycles in three runs of 4 ones, separated by 2 cycles with o_valid=0 and o_seq=0.
  - o_sof three times; o_done exactly 17 cycles after start.
- Back-to-back frames: pattern=3'b101, len=3, repeat=2, gap=0.
  - o_seq=1,0,1,1,0,1 continuous; o_sof on bits 1 and 4.
- Boundary inputs:
  - len=0: no o_busy, no o_done.
  - len=9 with MAX_LEN=8: 8 bits sent, first bit is pattern[7].
  - repeat=0: one frame sent.
- Ignored and aborted requests:
  - i_start pulsed mid-frame with a new pattern: current frame unchanged.
  - i_abort on the third bit: o_valid=0 next cycle, no o_done.
  - New start two cycles later: sends normally.
- Async reset: rst_n low mid-GAP.
  - All outputs 0 immediately.
  - After release, a start produces a correct frame from bit len-1.
  - Stream fed into seq_det_11x1: 1101 detected once.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the detector benches.
package seq_pkg;

   // Default geometry; LEN_W must satisfy 2**LEN_W > MAX_LEN.
   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_LEN_W   = 4;
   localparam int DEF_REP_W   = 8;
   localparam int DEF_GAP_W   = 4;

   // Transmitter state encoding, 2-bit binary.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/seq_gen_dncnt.sv
// Loadable down-counter with a zero flag. Load has priority over enable.
module seq_gen_dncnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         zero
);

   // Count register: load wins, otherwise decrement when enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/seq_gen_serial.sv
// Serial bit-pattern transmitter: shifts a captured pattern out MSB-first,
// repeating it with an optional idle gap between frames.
//
// Request/status handshake: i_start is a request that is honoured only while
// the FSM is IDLE (o_busy=0 and o_done=0); once accepted, the transmission runs
// to completion on captured copies of the inputs, and o_busy stays high until
// the final bit. o_done is a single-cycle completion pulse, not a level.
// i_abort returns to IDLE from any state and beats a simultaneous i_start.
module seq_gen_serial
   import seq_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int LEN_W   = DEF_LEN_W,
   parameter int REP_W   = DEF_REP_W,
   parameter int GAP_W   = DEF_GAP_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [MAX_LEN-1:0] i_pattern,
   input  logic [LEN_W-1:0]   i_len,
   input  logic [REP_W-1:0]   i_repeat,
   input  logic [GAP_W-1:0]   i_gap,
   output logic               o_seq,
   output logic               o_valid,
   output logic               o_sof,
   output logic               o_busy,
   output logic               o_done,
   output logic [1:0]         o_state
);

   state_t             state, nxt;

   // Shadow copies of the request, frozen for the whole transmission.
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic [GAP_W-1:0]   gap_q;

   // Counter controls and values.
   logic               idx_load, idx_en, idx_zero;
   logic [LEN_W-1:0]   idx_val, idx_cnt;
   logic               rep_load, rep_en, rep_zero;
   logic [REP_W-1:0]   rep_val, rep_cnt;
   logic               gap_load, gap_en, gap_zero;
   logic [GAP_W-1:0]   gap_val, gap_cnt;

   // Request capture and look-ahead values used to register the outputs.
   logic               cap;
   logic [LEN_W-1:0]   in_len;
   logic [LEN_W-1:0]   nxt_idx, nxt_len;
   logic [MAX_LEN-1:0] nxt_pat, pat_sh;
   logic               nxt_valid, nxt_seq, nxt_sof, nxt_busy, nxt_done;

   // Bit index within the current frame (counts len-1 down to 0).
   seq_gen_dncnt #(.W(LEN_W)) u_idx (
      .clk(clk), .rst_n(rst_n), .load(idx_load), .load_val(idx_val),
      .en(idx_en), .count(idx_cnt), .zero(idx_zero)
   );

   // Frames still to send after the current one (loaded with R-1).
   seq_gen_dncnt #(.W(REP_W)) u_rep (
      .clk(clk), .rst_n(rst_n), .load(rep_load), .load_val(rep_val),
      .en(rep_en), .count(rep_cnt), .zero(rep_zero)
   );

   // Remaining idle cycles in the current inter-frame gap (loaded with G-1).
   seq_gen_dncnt #(.W(GAP_W)) u_gap (
      .clk(clk), .rst_n(rst_n), .load(gap_load), .load_val(gap_val),
      .en(gap_en), .count(gap_cnt), .zero(gap_zero)
   );

   // Clamp an oversize length request to the pattern width.
   assign in_len = (i_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_len;

   // Next-state and counter control; abort overrides everything outside IDLE.
   always_comb begin
      nxt      = state;
      cap      = 1'b0;
      idx_load = 1'b0;
      idx_val  = len_q - LEN_W'(1);
      idx_en   = 1'b0;
      rep_load = 1'b0;
      rep_val  = '0;
      rep_en   = 1'b0;
      gap_load = 1'b0;
      gap_val  = gap_q - GAP_W'(1);
      gap_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!i_abort && i_start && (i_len != '0)) begin
               nxt      = ST_SHIFT;
               cap      = 1'b1;
               idx_load = 1'b1;
               idx_val  = in_len - LEN_W'(1);
               rep_load = 1'b1;
               rep_val  = (i_repeat == '0) ? '0 : i_repeat - REP_W'(1);
            end
         end
         ST_SHIFT: begin
            if (i_abort) begin
               nxt = ST_IDLE;
            end else if (!idx_zero) begin
               idx_en = 1'b1;
            end else if (rep_zero) begin
               nxt = ST_DONE;
            end else begin
               rep_en = 1'b1;
               if (gap_q == '0) begin
                  idx_load = 1'b1;
               end else begin
                  nxt      = ST_GAP;
                  gap_load = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (i_abort) begin
               nxt = ST_IDLE;
            end else if (gap_zero) begin
               nxt      = ST_SHIFT;
               idx_load = 1'b1;
            end else begin
               gap_en = 1'b1;
            end
         end
         ST_DONE: begin
            nxt = ST_IDLE;
         end
         default: begin
            nxt = ST_IDLE;
         end
      endcase
   end

   // Look ahead to the bit that will be on the line next cycle so the outputs
   // can be registered without adding a cycle of latency.
   always_comb begin
      nxt_idx   = idx_load ? idx_val : (idx_en ? idx_cnt - LEN_W'(1) : idx_cnt);
      nxt_len   = cap ? in_len : len_q;
      nxt_pat   = cap ? i_pattern : pat_q;
      pat_sh    = nxt_pat >> nxt_idx;
      nxt_valid = (nxt == ST_SHIFT);
      nxt_seq   = nxt_valid & pat_sh[0];
      nxt_sof   = nxt_valid && (nxt_idx == nxt_len - LEN_W'(1));
      nxt_busy  = (nxt == ST_SHIFT) || (nxt == ST_GAP);
      nxt_done  = (nxt == ST_DONE);
   end

   // State, shadow registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         gap_q   <= '0;
         o_seq   <= 1'b0;
         o_valid <= 1'b0;
         o_sof   <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         state   <= nxt;
         if (cap) begin
            pat_q <= i_pattern;
            len_q <= in_len;
            gap_q <= i_gap;
         end
         o_seq   <= nxt_seq;
         o_valid <= nxt_valid;
         o_sof   <= nxt_sof;
         o_busy  <= nxt_busy;
         o_done  <= nxt_done;
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_seq_gen_serial.sv
// Self-checking bench for seq_gen_serial: table of directed transmissions,
// randomized transmissions against a frame-level model, and hand-written
// abort / reset sequences.
module tb_seq_gen_serial;
   import seq_pkg::*;

   localparam int ML = DEF_MAX_LEN;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_start, i_abort;
   logic [ML-1:0] i_pattern;
   logic [3:0]    i_len;
   logic [7:0]    i_repeat;
   logic [3:0]    i_gap;
   logic          o_seq, o_valid, o_sof, o_busy, o_done;
   logic [1:0]    o_state;

   int total = 0;
   int bad   = 0;

   // Expected per-cycle outputs packed as {busy, valid, sof, seq, done}.
   logic [4:0] exp_q[$];

   typedef struct {
      logic [7:0] pat;
      logic [3:0] len;
      logic [7:0] rep;
      logic [3:0] gap;
      int         exp_valid;
      int         exp_done_off;
   } vec_t;

   vec_t tbl[7];

   seq_gen_serial dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
      .i_pattern(i_pattern), .i_len(i_len), .i_repeat(i_repeat), .i_gap(i_gap),
      .o_seq(o_seq), .o_valid(o_valid), .o_sof(o_sof), .o_busy(o_busy),
      .o_done(o_done), .o_state(o_state)
   );

   // Clock
   always #5 clk = ~clk;

   function automatic logic [4:0] outs();
      return {o_busy, o_valid, o_sof, o_seq, o_done};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Frame-level model: R frames of L bits MSB-first, G idle cycles between
   // frames, a done cycle, then one idle cycle.
   task automatic build_exp(input logic [7:0] pat, input logic [3:0] len,
                            input logic [7:0] rep, input logic [3:0] gap);
      int L, R, G;
      logic [7:0] sh;
      L = (int'(len) > ML) ? ML : int'(len);
      R = (rep == 8'd0) ? 1 : int'(rep);
      G = int'(gap);
      exp_q.delete();
      if (L == 0) begin
         repeat (3) exp_q.push_back(5'b00000);
         return;
      end
      for (int f = 0; f < R; f++) begin
         for (int b = L - 1; b >= 0; b--) begin
            sh = pat >> b;
            exp_q.push_back({1'b1, 1'b1, (b == L - 1), sh[0], 1'b0});
         end
         if (f < R - 1) repeat (G) exp_q.push_back(5'b10000);
      end
      exp_q.push_back(5'b00001);
      exp_q.push_back(5'b00000);
   endtask

   // Driver + scoreboard: call right after a negedge. While the model says the
   // transmitter is busy (or in its done cycle) the inputs are scrambled and
   // i_start is toggled randomly; none of that may disturb the stream.
   task automatic run_seq(input logic [7:0] pat, input logic [3:0] len,
                          input logic [7:0] rep, input logic [3:0] gap,
                          output int vcnt, output int done_off);
      logic [4:0] e, a;
      int off;
      build_exp(pat, len, rep, gap);
      vcnt = 0;
      done_off = -1;
      off = 0;
      i_pattern = pat;
      i_len = len;
      i_repeat = rep;
      i_gap = gap;
      i_abort = 1'b0;
      i_start = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         off++;
         e = exp_q.pop_front();
         a = outs();
         check($sformatf("out_cycle%0d", off), int'(a), int'(e));
         if (a[3]) vcnt++;
         if (a[0] && done_off < 0) done_off = off;
         if (exp_q.size() > 0 && (e[4] || e[0])) begin
            i_start   = 1'($urandom_range(0, 1));
            i_pattern = 8'($urandom);
            i_len     = 4'($urandom);
            i_repeat  = 8'($urandom);
            i_gap     = 4'($urandom);
         end else begin
            i_start = 1'b0;
         end
      end
      i_start = 1'b0;
   endtask

   initial begin
      int vc, dof;
      logic [7:0] rp;
      logic [3:0] rl, rg;
      logic [7:0] rr;

      tbl[0] = '{8'b0000_1101, 4'd4, 8'd1,   4'd0, 4,   5};
      tbl[1] = '{8'b0000_1111, 4'd4, 8'd3,   4'd2, 12,  17};
      tbl[2] = '{8'b0000_0101, 4'd3, 8'd2,   4'd0, 6,   7};
      tbl[3] = '{8'b1010_0101, 4'd9, 8'd1,   4'd0, 8,   9};
      tbl[4] = '{8'b0000_0011, 4'd2, 8'd0,   4'd1, 2,   3};
      tbl[5] = '{8'b1111_1111, 4'd0, 8'd1,   4'd0, 0,   -1};
      tbl[6] = '{8'b0000_0001, 4'd1, 8'd255, 4'd0, 255, 256};

      // Reset
      rst_n = 1'b0;
      i_start = 1'b0;
      i_abort = 1'b0;
      i_pattern = '0;
      i_len = '0;
      i_repeat = '0;
      i_gap = '0;
      @(negedge clk);
      @(negedge clk);
      check("reset_outs", int'(outs()), 0);
      check("reset_state", int'(o_state), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 7; i++) begin
         run_seq(tbl[i].pat, tbl[i].len, tbl[i].rep, tbl[i].gap, vc, dof);
         check($sformatf("tbl%0d_valid_cnt", i), vc, tbl[i].exp_valid);
         check($sformatf("tbl%0d_done_off", i), dof, tbl[i].exp_done_off);
      end

      // Randomized transmissions against the model
      for (int i = 0; i < 20; i++) begin
         rp = 8'($urandom);
         rl = 4'($urandom_range(0, 10));
         rr = 8'($urandom_range(0, 4));
         rg = 4'($urandom_range(0, 3));
         run_seq(rp, rl, rr, rg, vc, dof);
      end

      // Abort and start together in IDLE: abort wins
      i_pattern = 8'hFF; i_len = 4'd4; i_repeat = 8'd1; i_gap = 4'd0;
      i_start = 1'b1; i_abort = 1'b1;
      @(negedge clk);
      i_start = 1'b0; i_abort = 1'b0;
      check("abort_start_idle", int'(outs()), 0);
      @(negedge clk);
      check("abort_start_idle2", int'(outs()), 0);

      // Abort on the third bit
      i_pattern = 8'b0000_1011; i_len = 4'd4; i_repeat = 8'd2; i_gap = 4'd1;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check("abort_bit1", int'(outs()), 5'b11110);
      @(negedge clk);
      check("abort_bit2", int'(outs()), 5'b11000);
      @(negedge clk);
      check("abort_bit3", int'(outs()), 5'b11010);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      check("abort_next", int'(outs()), 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check($sformatf("abort_quiet%0d", k), int'(outs()), 0);
      end
      run_seq(8'b0000_0110, 4'd3, 8'd1, 4'd0, vc, dof);
      check("after_abort_valid", vc, 3);
      check("after_abort_done", dof, 4);

      // Async reset in the middle of a gap
      i_pattern = 8'b0000_1101; i_len = 4'd4; i_repeat = 8'd2; i_gap = 4'd3;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check("rst_bit1", int'(outs()), 5'b11110);
      @(negedge clk);
      check("rst_bit2", int'(outs()), 5'b11010);
      @(negedge clk);
      check("rst_bit3", int'(outs()), 5'b11000);
      @(negedge clk);
      check("rst_bit4", int'(outs()), 5'b11010);
      @(negedge clk);
      check("rst_gap", int'(outs()), 5'b10000);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_outs", int'(outs()), 0);
      check("rst_async_state", int'(o_state), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_seq(8'b0000_1101, 4'd4, 8'd1, 4'd0, vc, dof);
      check("after_rst_valid", vc, 4);
      check("after_rst_done", dof, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
